// File: rtl/gb_alu_pkg.sv
// gb_alu_pkg: opcodes, flag bit positions, FSM and slice-mode enums, and the
// decimal-adjust helper shared by the nibble-serial ALU.
package gb_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_SBC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_CP  = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_DAA = 4'hA;

  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FH = 1;
  localparam int FC = 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {L_ARITH, L_AND, L_XOR, L_OR} lmode_t;

  // Returns {C_out, adjusted byte}.
  function automatic logic [8:0] daa8(input logic [7:0] v, input logic n,
                                      input logic h, input logic cy);
    logic [7:0] adj;
    logic       co;
    adj = 8'h00;
    co  = cy;
    if (!n) begin
      if (cy || v > 8'h99) begin
        adj[7:4] = 4'h6;
        co       = 1'b1;
      end
      if (h || v[3:0] > 4'h9) adj[3:0] = 4'h6;
      return {co, v + adj};
    end else begin
      if (cy) adj[7:4] = 4'h6;
      if (h)  adj[3:0] = 4'h6;
      return {co, v - adj};
    end
  endfunction

endpackage

// File: rtl/gb_alu_seq_if.sv
// gb_alu_seq_if: request/result handshake bundle for the nibble-serial ALU.
interface gb_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       in_f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic [3:0]       f;
    logic             busy;

    modport master (
        output in_valid, op, a, b, in_f, out_ready,
        input  in_ready, out_valid, c, f, busy
    );

    modport slave (
        input  in_valid, op, a, b, in_f, out_ready,
        output in_ready, out_valid, c, f, busy
    );
endinterface

// File: rtl/gb_alu_slice.sv
// gb_alu_slice: combinational 4-bit add/sub/logic slice; cout is carry for
// add and borrow for sub.
module gb_alu_slice
    import gb_alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    input  lmode_t     mode,
    output logic [3:0] y,
    output logic       cout
);
    logic [4:0] sum;

    always_comb begin
        // Subtract as a + ~b + ~borrow; the borrow out is the inverted carry.
        sum  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {4'b0000, (sub ? ~cin : cin)};
        y    = sum[3:0];
        cout = 1'b0;
        case (mode)
            L_ARITH: cout = sum[4] ^ sub;
            L_AND:   y = a & b;
            L_XOR:   y = a ^ b;
            L_OR:    y = a | b;
            default: y = sum[3:0];
        endcase
    end
endmodule

// File: rtl/gb_alu_seq.sv
// gb_alu_seq: nibble-serial ALU, one WIDTH-bit op over WIDTH/4 RUN cycles.
// Define GB_ALU_DAA_EN to enable decimal adjust on op 1010; otherwise it is reserved.
module gb_alu_seq
    import gb_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    gb_alu_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = $clog2(NSLICE);
    localparam int SW     = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [3:0]       op_q, inf_q, f_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, h_q, zacc_q;

    logic             accept, last, first;
    logic [SW-1:0]    sel;
    logic             sub, cin0, zero_b, pass_a, slice_cin;
    lmode_t           lmode;
    logic [3:0]       a_nib, b_nib, y_nib, nib_out, f_next;
    logic             cout, z_now, h_now;
`ifdef GB_ALU_DAA_EN
    logic             daa_op;
    logic [8:0]       daa_r;
    logic [WIDTH-1:0] daa_full;
`endif

    assign accept = bus.in_valid && (state_q == S_IDLE);
    assign first  = (idx_q == '0);
    assign last   = (idx_q == IW'(NSLICE - 1));
    assign sel    = {idx_q, 2'b00};

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.c         = c_q;
    assign bus.f         = f_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
            S_RUN:   if (last)          state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Opcode decode into slice controls; pass_a ops keep a as the result.
    always_comb begin
        sub    = 1'b0;
        cin0   = 1'b0;
        zero_b = 1'b0;
        pass_a = 1'b0;
        lmode  = L_ARITH;
`ifdef GB_ALU_DAA_EN
        daa_op = 1'b0;
`endif
        case (op_q)
            OP_ADD: cin0 = 1'b0;
            OP_ADC: cin0 = inf_q[FC];
            OP_SUB: sub = 1'b1;
            OP_SBC: begin sub = 1'b1; cin0 = inf_q[FC]; end
            OP_CP:  begin sub = 1'b1; pass_a = 1'b1; end
            OP_AND: lmode = L_AND;
            OP_XOR: lmode = L_XOR;
            OP_OR:  lmode = L_OR;
            OP_INC: begin zero_b = 1'b1; cin0 = 1'b1; end
            OP_DEC: begin sub = 1'b1; zero_b = 1'b1; cin0 = 1'b1; end
`ifdef GB_ALU_DAA_EN
            OP_DAA: begin pass_a = 1'b1; daa_op = 1'b1; end
`endif
            default: pass_a = 1'b1;
        endcase
    end

    assign a_nib     = a_q[sel +: 4];
    assign b_nib     = zero_b ? 4'h0 : b_q[sel +: 4];
    assign slice_cin = first ? cin0 : carry_q;

    gb_alu_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (slice_cin),
        .sub  (sub),
        .mode (lmode),
        .y    (y_nib),
        .cout (cout)
    );

    assign nib_out = pass_a ? a_nib : y_nib;
    // Z tracks the computed value, so cp reports the subtraction, not a.
    assign z_now   = zacc_q && (y_nib == 4'h0);
    assign h_now   = first ? cout : h_q;

`ifdef GB_ALU_DAA_EN
    assign daa_r = daa8(a_q[7:0], inf_q[FN], inf_q[FH], inf_q[FC]);
    always_comb begin
        daa_full      = a_q;
        daa_full[7:0] = daa_r[7:0];
    end
`endif

    always_comb begin
        f_next = inf_q;
        case (op_q)
            OP_ADD, OP_ADC:        f_next = {z_now, 1'b0, h_now, cout};
            OP_SUB, OP_SBC, OP_CP: f_next = {z_now, 1'b1, h_now, cout};
            OP_AND:                f_next = {z_now, 3'b010};
            OP_XOR, OP_OR:         f_next = {z_now, 3'b000};
            OP_INC:                f_next = {z_now, 1'b0, h_now, inf_q[FC]};
            OP_DEC:                f_next = {z_now, 1'b1, h_now, inf_q[FC]};
`ifdef GB_ALU_DAA_EN
            OP_DAA:                f_next = {(daa_full == '0), inf_q[FN], 1'b0, daa_r[8]};
`endif
            default:               f_next = inf_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            inf_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            f_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            h_q     <= 1'b0;
            zacc_q  <= 1'b1;
        end else if (accept) begin
            op_q    <= bus.op;
            inf_q   <= bus.in_f;
            a_q     <= bus.a;
            b_q     <= bus.b;
            idx_q   <= '0;
            carry_q <= 1'b0;
            h_q     <= 1'b0;
            zacc_q  <= 1'b1;
        end else if (state_q == S_RUN) begin
            c_q[sel +: 4] <= nib_out;
            carry_q       <= cout;
            zacc_q        <= z_now;
            idx_q         <= idx_q + IW'(1);
            if (first) h_q <= cout;
            if (last) begin
                f_q <= f_next;
`ifdef GB_ALU_DAA_EN
                if (daa_op) c_q <= daa_full;
`endif
            end
        end
    end
endmodule

// File: tb/tb_gb_alu_seq.sv
// tb_gb_alu_seq: directed checks of the nibble-serial ALU at WIDTH=8 and WIDTH=16.
module tb_gb_alu_seq;
    import gb_alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gb_alu_seq_if #(.WIDTH(8))  i8 ();
    gb_alu_seq_if #(.WIDTH(16)) i16 ();

    gb_alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    gb_alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    logic [7:0]  c8;
    logic [3:0]  f8;
    logic [15:0] c16;
    logic [3:0]  f16;

    typedef struct packed {
        logic [3:0] op; logic [7:0] a; logic [7:0] b; logic [3:0] fi;
        logic [7:0] ec; logic [3:0] ef;
    } v8_t;
    typedef struct packed {
        logic [3:0] op; logic [15:0] a; logic [15:0] b; logic [3:0] fi;
        logic [15:0] ec; logic [3:0] ef;
    } v16_t;

    // Issue one op, scramble operand inputs after accept, wait for the result, then drain it.
    task automatic run8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic [3:0] fi);
        @(negedge clk);
        i8.in_valid = 1'b1; i8.op = o; i8.a = a; i8.b = b; i8.in_f = fi;
        @(posedge clk); #1;
        i8.in_valid = 1'b0; i8.op = 4'hF; i8.a = 8'hA5; i8.b = 8'h5A; i8.in_f = 4'hF;
        lat = 0;
        while (i8.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        c8 = i8.c; f8 = i8.f;
        i8.out_ready = 1'b1; @(posedge clk); #1; i8.out_ready = 1'b0;
    endtask

    task automatic run16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fi);
        @(negedge clk);
        i16.in_valid = 1'b1; i16.op = o; i16.a = a; i16.b = b; i16.in_f = fi;
        @(posedge clk); #1;
        i16.in_valid = 1'b0; i16.op = 4'hF; i16.a = 16'hA5A5; i16.b = 16'h5A5A; i16.in_f = 4'hF;
        lat = 0;
        while (i16.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        c16 = i16.c; f16 = i16.f;
        i16.out_ready = 1'b1; @(posedge clk); #1; i16.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({i8.in_ready, i8.out_valid, i8.busy, i8.c, i8.f} !== {3'b100, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset8 got rdy/vld/busy=%b%b%b c=%h f=%b want 100 c=00 f=0000",
                     i8.in_ready, i8.out_valid, i8.busy, i8.c, i8.f);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({i16.in_ready, i16.out_valid, i16.busy, i16.c, i16.f} !== {3'b100, 16'h0000, 4'h0}) begin
            n_fail++;
            $display("FAIL reset16 got rdy/vld/busy=%b%b%b c=%h f=%b want 100 c=0000 f=0000",
                     i16.in_ready, i16.out_valid, i16.busy, i16.c, i16.f);
        end
    endtask

    task automatic test_arith8();
        v8_t v [11];
        v[0]  = '{OP_ADD, 8'h3A, 8'hC6, 4'b0000, 8'h00, 4'b1011};
        v[1]  = '{OP_SBC, 8'h3B, 8'h2A, 4'b0001, 8'h10, 4'b0100};
        v[2]  = '{OP_CP,  8'h3E, 8'h3E, 4'b0000, 8'h3E, 4'b1100};
        v[3]  = '{OP_AND, 8'hF0, 8'h3C, 4'b0000, 8'h30, 4'b0010};
        v[4]  = '{OP_XOR, 8'h55, 8'h55, 4'b0001, 8'h00, 4'b1000};
        v[5]  = '{OP_OR,  8'h50, 8'h0A, 4'b0000, 8'h5A, 4'b0000};
        v[6]  = '{OP_DEC, 8'h00, 8'h77, 4'b0001, 8'hFF, 4'b0111};
        v[7]  = '{OP_ADC, 8'h0F, 8'h00, 4'b0001, 8'h10, 4'b0010};
        v[8]  = '{4'hF,   8'h12, 8'h34, 4'b1010, 8'h12, 4'b1010};
        v[9]  = '{OP_SUB, 8'h10, 8'h20, 4'b0000, 8'hF0, 4'b0101};
        v[10] = '{OP_INC, 8'hFF, 8'h33, 4'b0000, 8'h00, 4'b1010};
        for (int k = 0; k < 11; k++) begin
            run8(v[k].op, v[k].a, v[k].b, v[k].fi);
            n_chk++;
            if ({c8, f8} !== {v[k].ec, v[k].ef}) begin
                n_fail++;
                $display("FAIL arith8[%0d] got c=%h f=%b want c=%h f=%b", k, c8, f8, v[k].ec, v[k].ef);
            end
            n_chk++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL lat8[%0d] got %0d want 2", k, lat);
            end
        end
    endtask

    task automatic test_arith16();
        v16_t v [5];
        v[0] = '{OP_ADD, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b1011};
        v[1] = '{OP_INC, 16'h00FF, 16'h1234, 4'b0001, 16'h0100, 4'b0011};
        v[2] = '{OP_SUB, 16'h1000, 16'h0001, 4'b0000, 16'h0FFF, 4'b0110};
        v[3] = '{OP_DEC, 16'h0000, 16'hFFFF, 4'b0000, 16'hFFFF, 4'b0110};
        v[4] = '{OP_AND, 16'h1234, 16'hFF00, 4'b0000, 16'h1200, 4'b0010};
        for (int k = 0; k < 5; k++) begin
            run16(v[k].op, v[k].a, v[k].b, v[k].fi);
            n_chk++;
            if ({c16, f16} !== {v[k].ec, v[k].ef}) begin
                n_fail++;
                $display("FAIL arith16[%0d] got c=%h f=%b want c=%h f=%b", k, c16, f16, v[k].ec, v[k].ef);
            end
            n_chk++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL lat16[%0d] got %0d want 4", k, lat);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        i16.in_valid = 1'b1; i16.op = OP_SUB; i16.a = 16'h5555; i16.b = 16'h1111; i16.in_f = 4'h0;
        @(posedge clk); #1;
        i16.in_valid = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({i16.busy, i16.c[3:0]} !== {1'b1, 4'h4}) begin
            n_fail++;
            $display("FAIL midrun16 got busy=%b c=%h want busy=1 c[3:0]=4", i16.busy, i16.c);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({i16.out_valid, i16.busy, i16.c, i16.f} !== {2'b00, 16'h0000, 4'h0}) begin
            n_fail++;
            $display("FAIL rst_mid16 got vld=%b busy=%b c=%h f=%b want 0 0 0000 0000",
                     i16.out_valid, i16.busy, i16.c, i16.f);
        end
        @(negedge clk); rst_n = 1'b1;
        run16(OP_ADD, 16'hFFFF, 16'h0001, 4'h0);
        n_chk++;
        if ({c16, f16, lat[3:0]} !== {16'h0000, 4'b1011, 4'd4}) begin
            n_fail++;
            $display("FAIL after_rst16 got c=%h f=%b lat=%0d want c=0000 f=1011 lat=4", c16, f16, lat);
        end
    endtask

    task automatic test_daa();
        logic [7:0]  e8 [3];
        logic [3:0]  ef [4];
        logic [15:0] e16;
`ifdef GB_ALU_DAA_EN
        e8[0] = 8'h00; ef[0] = 4'b1001;
        e8[1] = 8'h09; ef[1] = 4'b0100;
        e8[2] = 8'h75; ef[2] = 4'b0001;
        e16   = 16'h124B; ef[3] = 4'b0000;
`else
        e8[0] = 8'h9A; ef[0] = 4'b0000;
        e8[1] = 8'h0F; ef[1] = 4'b0110;
        e8[2] = 8'h15; ef[2] = 4'b0001;
        e16   = 16'h1245; ef[3] = 4'b0010;
`endif
        run8(OP_DAA, 8'h9A, 8'h00, 4'b0000);
        n_chk++;
        if ({c8, f8, lat[3:0]} !== {e8[0], ef[0], 4'd2}) begin
            n_fail++;
            $display("FAIL daa8_add got c=%h f=%b lat=%0d want c=%h f=%b lat=2", c8, f8, lat, e8[0], ef[0]);
        end
        run8(OP_DAA, 8'h0F, 8'h00, 4'b0110);
        n_chk++;
        if ({c8, f8} !== {e8[1], ef[1]}) begin
            n_fail++;
            $display("FAIL daa8_sub got c=%h f=%b want c=%h f=%b", c8, f8, e8[1], ef[1]);
        end
        run8(OP_DAA, 8'h15, 8'h00, 4'b0001);
        n_chk++;
        if ({c8, f8} !== {e8[2], ef[2]}) begin
            n_fail++;
            $display("FAIL daa8_cy got c=%h f=%b want c=%h f=%b", c8, f8, e8[2], ef[2]);
        end
        run16(OP_DAA, 16'h1245, 16'h0000, 4'b0010);
        n_chk++;
        if ({c16, f16, lat[3:0]} !== {e16, ef[3], 4'd4}) begin
            n_fail++;
            $display("FAIL daa16 got c=%h f=%b lat=%0d want c=%h f=%b lat=4", c16, f16, lat, e16, ef[3]);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        i8.in_valid = 1'b1; i8.op = OP_ADD; i8.a = 8'h01; i8.b = 8'h02; i8.in_f = 4'h0;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // A competing request while DONE must be ignored.
        i8.in_valid = 1'b1; i8.op = OP_SUB; i8.a = 8'hFF; i8.b = 8'h01; i8.in_f = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({i8.out_valid, i8.in_ready, i8.busy, i8.c, i8.f} !== {3'b101, 8'h03, 4'h0}) begin
                n_fail++;
                $display("FAIL hold8[%0d] got vld/rdy/busy=%b%b%b c=%h f=%b want 101 c=03 f=0000",
                         k, i8.out_valid, i8.in_ready, i8.busy, i8.c, i8.f);
            end
        end
        i8.in_valid = 1'b0; i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.out_ready = 1'b0;
        n_chk++;
        if ({i8.out_valid, i8.in_ready, i8.busy, i8.c} !== {3'b010, 8'h03}) begin
            n_fail++;
            $display("FAIL release8 got vld/rdy/busy=%b%b%b c=%h want 010 c=03",
                     i8.out_valid, i8.in_ready, i8.busy, i8.c);
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int got;
        got = 0;
        @(negedge clk);
        i8.out_ready = 1'b1; i8.in_valid = 1'b1;
        i8.op = OP_ADD; i8.a = 8'h11; i8.b = 8'h22; i8.in_f = 4'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (i8.in_ready === 1'b1) acc.push_back(cyc);
            if (i8.out_valid === 1'b1) begin
                got++;
                n_chk++;
                if ({i8.c, i8.f} !== {8'h33, 4'h0}) begin
                    n_fail++;
                    $display("FAIL b2b_data cyc=%0d got c=%h f=%b want c=33 f=0000", cyc, i8.c, i8.f);
                end
            end
        end
        i8.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 i8.out_ready = 1'b0;
        n_chk++;
        if (got !== 5 || acc.size() !== 5) begin
            n_fail++;
            $display("FAIL b2b_count got results=%0d accepts=%0d want 5 and 5", got, acc.size());
        end
        for (int k = 1; k < acc.size(); k++) begin
            n_chk++;
            if (acc[k] - acc[k-1] !== 4) begin
                n_fail++;
                $display("FAIL b2b_period[%0d] got %0d want 4", k, acc[k] - acc[k-1]);
            end
        end
    endtask

    initial begin
        i8.in_valid = 1'b0; i8.op = '0; i8.a = '0; i8.b = '0; i8.in_f = '0; i8.out_ready = 1'b0;
        i16.in_valid = 1'b0; i16.op = '0; i16.a = '0; i16.b = '0; i16.in_f = '0; i16.out_ready = 1'b0;
        test_reset();
        test_arith8();
        test_arith16();
        test_reset_mid_run();
        test_daa();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/gb_alu_seq.md
# gb_alu_seq

Sequential, parametrised successor to the combinational CPU ALU. It executes one arithmetic/logic operation over a WIDTH-bit operand pair, 4 bits per cycle, through a nibble-serial datapath. Operands enter and results leave through valid/ready handshakes. The block sits between the decode stage and the register file, and serves both 8-bit accumulator ops and 16-bit (WIDTH=16) pair arithmetic on one datapath.

## Interface
- WIDTH, 8, operand/result width; multiple of 4, range 8..32
- NSLICE, WIDTH/4, derived slice count; not overridden
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  4  opcode: 0000 add, 0001 adc, 0010 sub, 0011 sbc, 0100 and, 0101 xor, 0110 or, 0111 cp, 1000 inc, 1001 dec, 1010 daa, others reserved
- a, b  in  WIDTH  operands (b ignored by inc/dec/daa)
- in_f  in  4  incoming flags {Z,N,H,C}
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- c  out  WIDTH  result
- f  out  4  result flags {Z,N,H,C}
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = ~in_ready.
- IDLE: on in_valid&&in_ready, latch op, a, b, in_f; clear slice index and carry; go to RUN.
- RUN: each cycle processes slice i (bits 4i+3..4i) with the registered carry/borrow and writes the result nibble. After slice NSLICE-1, go to DONE.
- DONE: hold c and f stable until out_valid&&out_ready, then go to IDLE.
- Carry-in: adc/sbc use in_f.C; inc/dec use a constant 1 with b=0.
- H is the carry/borrow out of bit 3. C is the carry/borrow out of bit WIDTH-1. Z means the full WIDTH-bit result is 0.
- add/adc: N=0. sub/sbc: N=1. cp: flags as sub, c=a.
- and: flags {Z,0,1,0}. xor/or: flags {Z,0,0,0}.
- inc: N=0, C=in_f.C. dec: N=1, C=in_f.C.
- Reserved op: c=a, f=in_f; the operation still completes with normal latency.
- All arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset (async, any state, including mid-RUN): state=IDLE, in_ready=1 after release, out_valid=0, busy=0, c=0, f=0. The in-flight op is discarded.
- Request accepted at edge T. Slices are computed at edges T+1..T+NSLICE. out_valid is high from edge T+NSLICE.
- WIDTH=8: 2 cycles to out_valid. WIDTH=16: 4 cycles.
- Earliest next accept is the edge after the result handshake. Throughput is 1 op per NSLICE+2 cycles when out_ready is held high.
- in_valid is ignored while busy. Operand inputs are not sampled outside the accept edge.
- If out_ready is low, DONE holds indefinitely with c and f unchanged.

## Configuration
- GB_ALU_DAA_EN defined: op 1010 performs decimal adjust on a[7:0], with a[WIDTH-1:8] passed through unchanged.
  - If N=0: add 0x60 and set C when C=1 or a[7:0]>0x99; add 0x06 when H=1 or the low nibble >9.
  - If N=1: subtract 0x60 if C=1; subtract 0x06 if H=1.
  - Z is computed over the full result. H=0. N is preserved. C is set per the rule above, otherwise preserved.
  - The result is applied at the final RUN cycle, so latency matches the other ops.
- GB_ALU_DAA_EN undefined: 1010 is treated as reserved (c=a, f=in_f).

## Structure
- Shared package gb_alu_pkg: opcode localparams, flag bit indices (FZ=3, FN=2, FH=1, FC=0), FSM state typedef.
- Sub-module gb_alu_slice: combinational 4-bit add/sub/logic slice with carry-in and carry-out, instantiated once and time-multiplexed by the slice index.

## Test plan
- WIDTH=8, add a=0x3A b=0xC6 -> c=0x00, f=1011, out_valid 2 cycles after accept.
- WIDTH=8, sbc a=0x3B b=0x2A in_f.C=1 -> c=0x10, f=0100; cp a=0x3E b=0x3E -> c=0x3E, f=1100.
- WIDTH=16, add a=0xFFFF b=0x0001 -> c=0x0000, f=1011, out_valid 4 cycles after accept; inc a=0x00FF in_f=0001 -> c=0x0100, f=0011.
- GB_ALU_DAA_EN, daa a=0x9A in_f=0000 -> c=0x00, f=1001. Without the macro, the same stimulus -> c=0x9A, f=0000.
- Backpressure: hold out_ready low 5 cycles in DONE -> c and f stable, in_ready=0, a new in_valid is ignored; one op per NSLICE+2 cycles with out_ready high.
- Assert rst_n low mid-RUN -> out_valid=0, c=0, f=0 immediately; the next request after release completes correctly.
